decode_stage: RTL and testbench

Instruction decode stage between the instruction-memory output of the fetch unit and the register file/ALU in `cpu_top`. Accepts one 10-bit instruction per handshake and produces registered read/write addresses, ALU control and immediate operand. Interlocks read-after-write hazards with a per-register scoreboard. Resolves jumps by driving `branch`/`branch_addr` into the fetch unit, and latches HALT.

---
 rtl/cpu_isa_pkg.sv | 45 ++++
 rtl/decode_scoreboard.sv | 56 +++++
 rtl/decode_stage.sv | 175 +++++++++++++++++
 tb/tb_decode_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 10-bit CPU: opcodes, field positions,
// ALU codes, decoded bundle layout and decode-stage states.
package cpu_isa_pkg;

    localparam logic [2:0] OP_ADDI = 3'b100;
    localparam logic [2:0] OP_LI   = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;
    localparam logic [2:0] OP_JMP  = 3'b111;

    localparam int OP_HI  = 9;
    localparam int OP_LO  = 7;
    localparam int RD_HI  = 6;
    localparam int RD_LO  = 4;
    localparam int RS_HI  = 3;
    localparam int RS_LO  = 1;
    localparam int F_BIT  = 0;
    localparam int IMM_HI = 3;
    localparam int IMM_LO = 0;
    localparam int TGT_HI = 6;
    localparam int TGT_LO = 0;

    localparam logic [2:0] ALU_ADD = 3'b000;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0] raddr1;
        logic [2:0] raddr2;
        logic [2:0] waddr;
        logic       we;
        logic [2:0] alu_ctrl;
        logic       use_imm;
        logic       a_zero;
        logic [9:0] imm;
    } bundle_t;

    function automatic logic is_reg_reg(input logic [2:0] op);
        return op[2] == 1'b0;
    endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Per-register pending-write counters and the read-after-write hazard check
// for up to two source registers of the instruction being offered.
module decode_scoreboard
    import cpu_isa_pkg::*;
#(
    parameter int EX_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_en,
    input  logic [2:0] set_addr,
    input  logic       src1_en,
    input  logic [2:0] src1_addr,
    input  logic       src2_en,
    input  logic [2:0] src2_addr,
    input  logic       inflight_we,
    input  logic [2:0] inflight_addr,
    output logic       hazard
);

    localparam logic [1:0] LAT = 2'(EX_LAT);

    logic [7:0] busy;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pend
            logic [1:0] pend_q;
            logic [1:0] pend_d;

            // A fresh write-back restarts the count even if it was still draining.
            always_comb begin
                pend_d = pend_q;
                if (set_en && (set_addr == 3'(gi))) begin
                    pend_d = LAT;
                end else if (pend_q != 2'd0) begin
                    pend_d = pend_q - 2'd1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    pend_q <= 2'd0;
                end else begin
                    pend_q <= pend_d;
                end
            end

            assign busy[gi] = (pend_q != 2'd0) ||
                              (inflight_we && (inflight_addr == 3'(gi)));
        end
    endgenerate

    assign hazard = (src1_en && busy[src1_addr]) || (src2_en && busy[src2_addr]);

endmodule

// File: rtl/decode_stage.sv
// Decode stage: turns one instruction per handshake into a registered
// register-file/ALU bundle, interlocks RAW hazards, redirects on JMP, stops on HALT.
module decode_stage
    import cpu_isa_pkg::*;
#(
    parameter int EX_LAT    = 1,
    parameter int FLUSH_CYC = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [9:0] in_instr,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_raddr1,
    output logic [2:0] out_raddr2,
    output logic [2:0] out_waddr,
    output logic       out_we,
    output logic [2:0] out_alu_ctrl,
    output logic       out_use_imm,
    output logic       out_a_zero,
    output logic [9:0] out_imm,
    output logic       branch,
    output logic [9:0] branch_addr,
    output logic       halted
);

    localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYC - 1);

    state_e     state_q, state_d;
    logic [1:0] flush_cnt_q, flush_cnt_d;
    logic       out_valid_q, out_valid_d;
    bundle_t    bundle_q, bundle_d;
    logic       branch_q, branch_d;
    logic [9:0] branch_addr_q, branch_addr_d;

    logic [2:0] op, rd, rs;
    logic       f;
    logic [3:0] imm4;
    logic [6:0] tgt;
    bundle_t    dec;
    logic       hazard;
    logic       accept;

    assign op   = in_instr[OP_HI:OP_LO];
    assign rd   = in_instr[RD_HI:RD_LO];
    assign rs   = in_instr[RS_HI:RS_LO];
    assign f    = in_instr[F_BIT];
    assign imm4 = in_instr[IMM_HI:IMM_LO];
    assign tgt  = in_instr[TGT_HI:TGT_LO];

    always_comb begin
        dec = '0;
        if (is_reg_reg(op)) begin
            dec.raddr1   = rd;
            dec.raddr2   = rs;
            dec.waddr    = rd;
            dec.we       = 1'b1;
            dec.alu_ctrl = {op[1:0], f};
        end else if (op == OP_ADDI) begin
            dec.raddr1   = rd;
            dec.waddr    = rd;
            dec.we       = 1'b1;
            dec.alu_ctrl = ALU_ADD;
            dec.use_imm  = 1'b1;
            dec.imm      = {{6{imm4[3]}}, imm4};
        end else if (op == OP_LI) begin
            dec.waddr    = rd;
            dec.we       = 1'b1;
            dec.alu_ctrl = ALU_ADD;
            dec.use_imm  = 1'b1;
            dec.a_zero   = 1'b1;
            dec.imm      = {6'b000000, imm4};
        end
    end

    // The bundle sitting in the output register counts as in flight even in
    // the cycle it is being accepted, so a dependent cannot issue under it.
    decode_scoreboard #(
        .EX_LAT(EX_LAT)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .set_en        (out_valid_q && out_ready && bundle_q.we),
        .set_addr      (bundle_q.waddr),
        .src1_en       (is_reg_reg(op) || (op == OP_ADDI)),
        .src1_addr     (rd),
        .src2_en       (is_reg_reg(op)),
        .src2_addr     (rs),
        .inflight_we   (out_valid_q && bundle_q.we),
        .inflight_addr (bundle_q.waddr),
        .hazard        (hazard)
    );

    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_RUN:   in_ready = (!out_valid_q || out_ready) && !hazard;
                ST_FLUSH: in_ready = 1'b1;
                default:  in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        out_valid_d   = out_valid_q && !out_ready;
        bundle_d      = bundle_q;
        branch_d      = 1'b0;
        branch_addr_d = branch_addr_q;
        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    if (op == OP_JMP) begin
                        branch_d      = 1'b1;
                        branch_addr_d = {3'b000, tgt};
                        state_d       = ST_FLUSH;
                        flush_cnt_d   = FLUSH_LAST;
                    end else if (op == OP_HALT) begin
                        state_d = ST_HALTED;
                    end else begin
                        out_valid_d = 1'b1;
                        bundle_d    = dec;
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == 2'd0) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 2'd1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            flush_cnt_q   <= 2'd0;
            out_valid_q   <= 1'b0;
            bundle_q      <= '0;
            branch_q      <= 1'b0;
            branch_addr_q <= 10'd0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            out_valid_q   <= out_valid_d;
            bundle_q      <= bundle_d;
            branch_q      <= branch_d;
            branch_addr_q <= branch_addr_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_raddr1   = bundle_q.raddr1;
    assign out_raddr2   = bundle_q.raddr2;
    assign out_waddr    = bundle_q.waddr;
    assign out_we       = bundle_q.we;
    assign out_alu_ctrl = bundle_q.alu_ctrl;
    assign out_use_imm  = bundle_q.use_imm;
    assign out_a_zero   = bundle_q.a_zero;
    assign out_imm      = bundle_q.imm;
    assign branch       = branch_q;
    assign branch_addr  = branch_addr_q;
    assign halted       = (state_q == ST_HALTED);

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios followed by a randomized run
// checked against a timestamp-based model of the decode rules.
module tb_decode_stage;

    localparam int EX_LAT    = 1;
    localparam int FLUSH_CYC = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] in_instr = 10'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [2:0] out_raddr1, out_raddr2, out_waddr, out_alu_ctrl;
    logic       out_we, out_use_imm, out_a_zero;
    logic [9:0] out_imm;
    logic       branch;
    logic [9:0] branch_addr;
    logic       halted;

    int nvec = 0;
    int nerr = 0;

    typedef struct packed {
        logic [2:0] raddr1;
        logic [2:0] raddr2;
        logic [2:0] waddr;
        logic       we;
        logic [2:0] alu;
        logic       use_imm;
        logic       a_zero;
        logic [9:0] imm;
    } exp_bundle_t;

    decode_stage #(
        .EX_LAT    (EX_LAT),
        .FLUSH_CYC (FLUSH_CYC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_raddr1   (out_raddr1),
        .out_raddr2   (out_raddr2),
        .out_waddr    (out_waddr),
        .out_we       (out_we),
        .out_alu_ctrl (out_alu_ctrl),
        .out_use_imm  (out_use_imm),
        .out_a_zero   (out_a_zero),
        .out_imm      (out_imm),
        .branch       (branch),
        .branch_addr  (branch_addr),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    // Expected bundle from the instruction rules, using plain integer arithmetic.
    function automatic exp_bundle_t ref_decode(input logic [9:0] w);
        exp_bundle_t b;
        int op, rd, rs, fb, imm4;
        b    = '0;
        op   = int'(w) / 128;
        rd   = (int'(w) / 16) % 8;
        rs   = (int'(w) / 2) % 8;
        fb   = int'(w) % 2;
        imm4 = int'(w) % 16;
        if (op < 4) begin
            b.raddr1 = 3'(rd); b.raddr2 = 3'(rs); b.waddr = 3'(rd);
            b.we = 1'b1; b.alu = 3'(op * 2 + fb);
        end else if (op == 4) begin
            b.raddr1 = 3'(rd); b.waddr = 3'(rd); b.we = 1'b1; b.use_imm = 1'b1;
            b.imm = 10'((imm4 >= 8) ? imm4 - 16 : imm4);
        end else if (op == 5) begin
            b.waddr = 3'(rd); b.we = 1'b1; b.use_imm = 1'b1; b.a_zero = 1'b1;
            b.imm = 10'(imm4);
        end
        return b;
    endfunction

    function automatic logic [9:0] rand_instr();
        int r;
        logic [9:0] w;
        logic [2:0] op;
        r = $urandom_range(0, 99);
        w = 10'($urandom);
        if (r < 55)      op = 3'($urandom_range(0, 3));
        else if (r < 75) op = 3'd4;
        else if (r < 90) op = 3'd5;
        else if (r < 97) op = 3'd7;
        else             op = 3'd6;
        w[9:7] = op;
        w[6]   = 1'b0;   // keep rd in r0..r3 so hazards happen often
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_instr = 10'd0;
        step(); step();
        @(negedge clk);
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        nvec++; if (branch !== 1'b0) begin nerr++; $display("FAIL reset_branch: got %b want 0", branch); end
        nvec++; if (halted !== 1'b0) begin nerr++; $display("FAIL reset_halted: got %b want 0", halted); end
        nvec++; if ({out_raddr1, out_raddr2, out_waddr, out_we, out_alu_ctrl, out_use_imm, out_a_zero, out_imm} !== 25'd0) begin
            nerr++; $display("FAIL reset_bundle: got nonzero bundle waddr=%0d imm=%h want all 0", out_waddr, out_imm); end
        nvec++; if (branch_addr !== 10'd0) begin nerr++; $display("FAIL reset_branch_addr: got %h want 000", branch_addr); end
        step(); reset = 1'b0;
        @(negedge clk);
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
        $display("reset: released, in_ready=%b", in_ready);
    endtask

    task automatic test_add();
        step(); in_valid = 1'b1; in_instr = 10'h032; out_ready = 1'b1;
        @(negedge clk);
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL add_in_ready: got %b want 1", in_ready); end
        step(); in_valid = 1'b0;
        @(negedge clk);
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL add_valid: got %b want 1", out_valid); end
        nvec++; if ({out_raddr1, out_raddr2, out_waddr, out_we, out_alu_ctrl} !== {3'd3, 3'd1, 3'd3, 1'b1, 3'b000}) begin
            nerr++; $display("FAIL add_fields: got r1=%0d r2=%0d w=%0d we=%b alu=%b want r1=3 r2=1 w=3 we=1 alu=000",
                             out_raddr1, out_raddr2, out_waddr, out_we, out_alu_ctrl); end
        nvec++; if ({out_use_imm, out_a_zero, out_imm} !== 12'd0) begin
            nerr++; $display("FAIL add_unused: got use_imm=%b a_zero=%b imm=%h want 0 0 000", out_use_imm, out_a_zero, out_imm); end
        $display("add: 0x032 -> r1=%0d r2=%0d w=%0d alu=%b", out_raddr1, out_raddr2, out_waddr, out_alu_ctrl);
        repeat (4) step();
    endtask

    task automatic test_imm();
        step(); in_valid = 1'b1; in_instr = 10'h21F;
        step(); in_instr = 10'h2A5;
        @(negedge clk);
        nvec++; if ({out_valid, out_imm, out_use_imm, out_a_zero, out_raddr1, out_waddr} !== {1'b1, 10'h3FF, 1'b1, 1'b0, 3'd1, 3'd1}) begin
            nerr++; $display("FAIL addi_fields: got v=%b imm=%h ui=%b az=%b r1=%0d w=%0d want 1 3ff 1 0 1 1",
                             out_valid, out_imm, out_use_imm, out_a_zero, out_raddr1, out_waddr); end
        $display("addi: 0x21F -> imm=%h", out_imm);
        step(); in_valid = 1'b0;
        @(negedge clk);
        nvec++; if ({out_valid, out_waddr, out_imm, out_a_zero, out_use_imm, out_raddr1} !== {1'b1, 3'd2, 10'h005, 1'b1, 1'b1, 3'd0}) begin
            nerr++; $display("FAIL li_fields: got v=%b w=%0d imm=%h az=%b ui=%b r1=%0d want 1 2 005 1 1 0",
                             out_valid, out_waddr, out_imm, out_a_zero, out_use_imm, out_raddr1); end
        $display("li: 0x2A5 -> w=%0d imm=%h", out_waddr, out_imm);
        repeat (4) step();
    endtask

    task automatic test_raw_stall();
        step(); in_valid = 1'b1; in_instr = 10'h2A5;
        @(negedge clk);
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL raw_first_ready: got %b want 1", in_ready); end
        step(); in_instr = 10'h044;
        @(negedge clk);
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL raw_stall1: got in_ready=%b want 0", in_ready); end
        step();
        @(negedge clk);
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL raw_stall2: got in_ready=%b want 0", in_ready); end
        step();
        @(negedge clk);
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL raw_release: got in_ready=%b want 1", in_ready); end
        step(); in_valid = 1'b0;
        @(negedge clk);
        nvec++; if ({out_valid, out_raddr1, out_raddr2, out_waddr} !== {1'b1, 3'd4, 3'd2, 3'd4}) begin
            nerr++; $display("FAIL raw_issue: got v=%b r1=%0d r2=%0d w=%0d want 1 4 2 4", out_valid, out_raddr1, out_raddr2, out_waddr); end
        $display("raw: 0x044 issued after stall, r2=%0d", out_raddr2);
        repeat (4) step();
    endtask

    task automatic test_backpressure();
        step(); in_valid = 1'b1; in_instr = 10'h032; out_ready = 1'b0;
        step(); in_instr = 10'h2A5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nvec++; if ({out_valid, out_waddr, out_raddr2, in_ready} !== {1'b1, 3'd3, 3'd1, 1'b0}) begin
                nerr++; $display("FAIL bp_hold%0d: got v=%b w=%0d r2=%0d in_ready=%b want 1 3 1 0",
                                 i, out_valid, out_waddr, out_raddr2, in_ready); end
            if (i < 2) step();
        end
        step(); out_ready = 1'b1;
        @(negedge clk);
        nvec++; if ({in_ready, out_waddr} !== {1'b1, 3'd3}) begin
            nerr++; $display("FAIL bp_release: got in_ready=%b w=%0d want 1 3", in_ready, out_waddr); end
        step(); in_valid = 1'b0;
        @(negedge clk);
        nvec++; if ({out_valid, out_waddr, out_a_zero} !== {1'b1, 3'd2, 1'b1}) begin
            nerr++; $display("FAIL bp_next: got v=%b w=%0d az=%b want 1 2 1", out_valid, out_waddr, out_a_zero); end
        $display("backpressure: held 3 cycles, then transferred");
        repeat (4) step();
    endtask

    task automatic test_jmp();
        step(); in_valid = 1'b1; in_instr = 10'h3C5;
        @(negedge clk);
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL jmp_ready: got %b want 1", in_ready); end
        step(); in_instr = 10'h032;
        @(negedge clk);
        nvec++; if ({branch, branch_addr} !== {1'b1, 10'h045}) begin
            nerr++; $display("FAIL jmp_branch: got branch=%b addr=%h want 1 045", branch, branch_addr); end
        nvec++; if ({in_ready, out_valid} !== 2'b10) begin
            nerr++; $display("FAIL jmp_flush: got in_ready=%b v=%b want 1 0", in_ready, out_valid); end
        step(); in_valid = 1'b0;
        @(negedge clk);
        nvec++; if ({branch, out_valid} !== 2'b00) begin
            nerr++; $display("FAIL jmp_after: got branch=%b v=%b want 0 0", branch, out_valid); end
        step();
        @(negedge clk);
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL jmp_dropped: got v=%b want 0", out_valid); end
        $display("jmp: 0x3C5 -> branch to %h, 0x032 dropped", branch_addr);
        repeat (2) step();
    endtask

    task automatic test_halt_reset();
        step(); in_valid = 1'b1; in_instr = 10'h300;
        @(negedge clk);
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL halt_ready: got %b want 1", in_ready); end
        step(); in_instr = 10'h032;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nvec++; if ({halted, in_ready, out_valid} !== 3'b100) begin
                nerr++; $display("FAIL halt_hold%0d: got halted=%b in_ready=%b v=%b want 1 0 0", i, halted, in_ready, out_valid); end
            step();
        end
        reset = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL halt_in_reset: got in_ready=%b want 0", in_ready); end
        step(); reset = 1'b0; in_valid = 1'b1; in_instr = 10'h032;
        @(negedge clk);
        nvec++; if ({halted, in_ready} !== 2'b01) begin
            nerr++; $display("FAIL halt_cleared: got halted=%b in_ready=%b want 0 1", halted, in_ready); end
        step(); in_valid = 1'b0;
        @(negedge clk);
        nvec++; if ({out_valid, out_waddr, out_raddr2} !== {1'b1, 3'd3, 3'd1}) begin
            nerr++; $display("FAIL halt_resume: got v=%b w=%0d r2=%0d want 1 3 1", out_valid, out_waddr, out_raddr2); end
        $display("halt: halted then reset, 0x032 decoded");
        repeat (4) step();
    endtask

    task automatic test_random(input int ncyc);
        int          busy_until [8];
        int          cyc;
        bit          m_valid, m_halted, m_branch, rst, exp_ready, haz, xfer, acc, nbr;
        int          flush_left, op, rd, rs;
        logic [9:0]  m_baddr;
        exp_bundle_t m_b, dut_b;

        step(); reset = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        step();
        for (int r = 0; r < 8; r++) busy_until[r] = -1;
        cyc = 0; m_valid = 0; m_halted = 0; m_branch = 0; flush_left = 0;
        m_baddr = 10'd0; m_b = '0;

        for (int c = 0; c < ncyc; c++) begin
            rst       = m_halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
            reset     = rst;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);

            op = int'(in_instr) / 128;
            rd = (int'(in_instr) / 16) % 8;
            rs = (int'(in_instr) / 2) % 8;
            haz = 0;
            if (op <= 4) begin
                if (cyc <= busy_until[rd] || (m_valid && m_b.we && int'(m_b.waddr) == rd)) haz = 1;
            end
            if (op < 4) begin
                if (cyc <= busy_until[rs] || (m_valid && m_b.we && int'(m_b.waddr) == rs)) haz = 1;
            end
            if (rst || m_halted)     exp_ready = 0;
            else if (flush_left > 0) exp_ready = 1;
            else                     exp_ready = (!m_valid || out_ready) && !haz;

            dut_b = {out_raddr1, out_raddr2, out_waddr, out_we, out_alu_ctrl, out_use_imm, out_a_zero, out_imm};
            nvec++; if (out_valid !== m_valid) begin nerr++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, out_valid, m_valid); end
            if (m_valid) begin
                nvec++; if (dut_b !== m_b) begin nerr++; $display("FAIL rnd_bundle c=%0d: got %h want %h", c, dut_b, m_b); end
            end
            nvec++; if (branch !== m_branch) begin nerr++; $display("FAIL rnd_branch c=%0d: got %b want %b", c, branch, m_branch); end
            if (m_branch) begin
                nvec++; if (branch_addr !== m_baddr) begin nerr++; $display("FAIL rnd_baddr c=%0d: got %h want %h", c, branch_addr, m_baddr); end
            end
            nvec++; if (halted !== m_halted) begin nerr++; $display("FAIL rnd_halted c=%0d: got %b want %b", c, halted, m_halted); end
            nvec++; if (in_ready !== exp_ready) begin
                nerr++; $display("FAIL rnd_in_ready c=%0d instr=%h: got %b want %b", c, in_instr, in_ready, exp_ready); end

            if (rst) begin
                for (int r = 0; r < 8; r++) busy_until[r] = -1;
                m_valid = 0; m_halted = 0; m_branch = 0; flush_left = 0; m_baddr = 10'd0; m_b = '0;
                $display("rnd c=%0d reset", c);
            end else begin
                xfer = m_valid && out_ready;
                acc  = in_valid && exp_ready;
                nbr  = 0;
                if (xfer) begin
                    if (m_b.we) busy_until[m_b.waddr] = cyc + EX_LAT;
                    m_valid = 0;
                    $display("rnd c=%0d xfer w=%0d we=%b imm=%h", c, m_b.waddr, m_b.we, m_b.imm);
                end
                if (flush_left > 0) begin
                    flush_left--;
                end else if (!m_halted && acc) begin
                    if (op == 7) begin
                        nbr = 1; m_baddr = in_instr & 10'h07F; flush_left = FLUSH_CYC;
                    end else if (op == 6) begin
                        m_halted = 1;
                    end else begin
                        m_b = ref_decode(in_instr); m_valid = 1;
                    end
                end
                m_branch = nbr;
            end
            cyc++;
            step();
        end
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_imm();
        test_raw_stall();
        test_backpressure();
        test_jmp();
        test_halt_reset();
        test_random(1500);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
